// File: rtl/btn_event.sv
// btn_event: turns a debounced button level into press/release/long/repeat pulses.
// Ports: clk, rst (async, active-high), btn_i (level), press_o/release_o/long_o/repeat_o (pulses), held_o (level).
module btn_event #(
    parameter int clock_freq = 100000000,
    parameter int long_ms    = 1000,
    parameter int repeat_ms  = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int          TICK      = clock_freq / 1000;
    localparam logic [16:0] TICK_LAST = 17'(TICK - 1);
    localparam logic [15:0] LONG_LAST = 16'(long_ms - 1);
    localparam logic [15:0] REP_LAST  = 16'(repeat_ms - 1);

    if (TICK < 2) begin : g_bad_tick
        $error("btn_event: clock_freq/1000 must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] presc_q, presc_d;
    logic [15:0] ms_q, ms_d;
    logic        btn_prev_q;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;
    logic        repeat_q, repeat_d;
    logic        held_q, held_d;
    logic        tick;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        ms_d      = ms_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        tick      = (presc_q == TICK_LAST);

        case (state_q)
            IDLE: begin
                presc_d = '0;
                ms_d    = '0;
                // Require a seen 0 first so a button held through reset stays silent.
                if (btn_i && !btn_prev_q) begin
                    press_d = 1'b1;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                presc_d = tick ? '0 : presc_q + 17'd1;
                ms_d    = tick ? ms_q + 16'd1 : ms_q;
                // Release wins over a long event due in the same cycle.
                if (!btn_i) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                    presc_d   = '0;
                    ms_d      = '0;
                end else if (tick && ms_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                    presc_d = '0;
                    ms_d    = '0;
                end
            end
            LONG: begin
                presc_d = tick ? '0 : presc_q + 17'd1;
                ms_d    = tick ? ms_q + 16'd1 : ms_q;
                if (!btn_i) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                    presc_d   = '0;
                    ms_d      = '0;
                end else if (tick && ms_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    presc_d  = '0;
                    ms_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
                ms_d    = '0;
            end
        endcase

        held_d = (state_d == PRESSED) || (state_d == LONG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            ms_q       <= '0;
            btn_prev_q <= 1'b1;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            ms_q       <= ms_d;
            btn_prev_q <= btn_i;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            held_q     <= held_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;
    assign held_o    = held_q;

endmodule

// File: tb/tb_btn_event.sv
// tb_btn_event: directed bench for btn_event with TICK=10, long_ms=5, repeat_ms=2.
// Output vector order is {press, release, long, repeat, held}.
module tb_btn_event;

    logic clk;
    logic rst;
    logic btn_i;
    logic press_o, release_o, long_o, repeat_o, held_o;
    logic [4:0] outs;

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] Z  = 5'b00000;
    localparam logic [4:0] P  = 5'b10001;
    localparam logic [4:0] R  = 5'b01000;
    localparam logic [4:0] L  = 5'b00100;
    localparam logic [4:0] RP = 5'b00010;
    localparam logic [4:0] H  = 5'b00001;

    btn_event #(
        .clock_freq(10000),
        .long_ms   (5),
        .repeat_ms (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn_i),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o),
        .repeat_o (repeat_o),
        .held_o   (held_o)
    );

    assign outs = {press_o, release_o, long_o, repeat_o, held_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply btn level, let one rising edge sample it, check on the falling edge.
    task automatic cyc(input logic b, input logic [4:0] exp, input string tag);
        btn_i = b;
        @(negedge clk);
        chk(tag, outs, exp);
    endtask

    initial begin
        logic [4:0] e;
        rst   = 1'b1;
        btn_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", outs, Z);
        rst = 1'b0;

        // Held through reset: no press until a 0 is seen.
        for (int i = 0; i < 3; i++) cyc(1'b1, Z, "held_thru_reset");
        cyc(1'b0, Z, "idle_low");

        // Short press of 20 cycles.
        cyc(1'b1, P, "short_press");
        for (int i = 0; i < 19; i++) cyc(1'b1, H, "short_held");
        cyc(1'b0, R, "short_release");
        cyc(1'b0, Z, "short_idle");

        // Long hold of 120 cycles: long at +50, repeats at +70/+90/+110.
        for (int k = 1; k <= 120; k++) begin
            e = H;
            if (k == 1) e = P;
            if (k == 51) e = H | L;
            if (k == 71 || k == 91 || k == 111) e = H | RP;
            cyc(1'b1, e, "long_hold");
        end
        cyc(1'b0, R, "long_release");
        cyc(1'b0, Z, "long_idle");

        // Release on the very edge the long event would fire.
        for (int k = 1; k <= 50; k++) cyc(1'b1, (k == 1) ? P : H, "coin_hold");
        cyc(1'b0, R, "coin_release_only");
        cyc(1'b0, Z, "coin_idle");

        // Reset in the middle of a long hold.
        for (int k = 1; k <= 60; k++) begin
            e = H;
            if (k == 1) e = P;
            if (k == 51) e = H | L;
            cyc(1'b1, e, "rst_mid_hold");
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_async", outs, Z);
        @(negedge clk);
        chk("rst_mid_held", outs, Z);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b1, Z, "no_press_after_rst");
        cyc(1'b0, Z, "rst_low");
        cyc(1'b1, P, "press_after_rst");
        cyc(1'b0, R, "release_after_rst");
        cyc(1'b0, Z, "idle_after_rst");

        // Rapid re-press with a single low cycle.
        cyc(1'b1, P, "rapid_press1");
        for (int i = 0; i < 4; i++) cyc(1'b1, H, "rapid_held1");
        cyc(1'b0, R, "rapid_release1");
        cyc(1'b1, P, "rapid_press2");
        for (int i = 0; i < 4; i++) cyc(1'b1, H, "rapid_held2");
        cyc(1'b0, R, "rapid_release2");
        cyc(1'b0, Z, "rapid_idle");

        // Short reset pulse between clock edges.
        cyc(1'b1, P, "async_press");
        cyc(1'b1, H, "async_held");
        cyc(1'b1, H, "async_held2");
        #1 rst = 1'b1;
        #1 chk("async_clear", outs, Z);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("async_no_press", outs, Z);
        cyc(1'b1, Z, "async_still_idle");
        cyc(1'b0, Z, "async_low");
        cyc(1'b1, P, "async_repress");
        cyc(1'b0, R, "async_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
